dac_lane_gearbox: RTL and testbench
===================================

Name: dac_lane_gearbox

Overview:
Single-clock, parametrised lane-ratio converter between the system-side sample stream and the OSERDES feed of a multiplexed DAC interface.
- Accepts IN_LANES samples per beat (valid/ready) and emits OUT_LANES samples per downstream strobe, in strict sample order.
- Generalises the fixed 5-lane / 4-phase demux: any lane ratio, configurable buffering, prefill threshold, underflow detection/recovery with idle-code insertion.

Parameters:
WIDTH, 14, bits per DAC sample
IN_LANES, 5, samples per input beat
OUT_LANES, 4, samples per output strobe
BUF_WORDS, 16, sample buffer depth; must be >= IN_LANES+OUT_LANES-1 (no deadlock)
PREFILL, 8, fill level to enter RUN; OUT_LANES <= PREFILL <= BUF_WORDS
IDLE_CODE, 0, sample value emitted when no data is available (two's complement)

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&&s_ready
s_data  in  IN_LANES*WIDTH  lane 0 = oldest sample
m_en  in  1  downstream requests OUT_LANES samples this cycle
m_valid  out  1  m_data valid (registered response to m_en)
m_data  out  OUT_LANES*WIDTH  lane 0 = oldest sample
fill  out  $clog2(BUF_WORDS+1)  samples currently buffered
running  out  1  state==RUN
underflow  out  1  sticky underflow flag
underflow_cnt  out  16  saturating underflow event count
uf_clear  in  1  clears underflow and underflow_cnt

Behaviour:
- Reset (sync, active-high): fill=0, state=PREFILL, m_valid=0, m_data=all IDLE_CODE (encoded), underflow=0, underflow_cnt=0, running=0. Reset overrides all inputs.
- s_ready is combinational from registered fill only: s_ready = (fill <= BUF_WORDS-IN_LANES). No combinational path from s_valid or m_en.
- Push: s_valid&&s_ready at cycle t; samples are appended behind existing data, visible in fill at t+1.
- Pop: only in RUN, only when m_en=1 and fill >= OUT_LANES at t. Removes the oldest OUT_LANES samples (pre-push contents only); m_data/m_valid present them at t+1.
- fill_next = fill + (push ? IN_LANES : 0) - (pop ? OUT_LANES : 0). Simultaneous push and pop are always legal.
- m_valid(t+1) = m_en(t) in every state. Whenever m_en=1 without a pop, m_data = all lanes IDLE_CODE. m_data holds its last value when m_en=0.
- State PREFILL: no pops; m_en yields idle words and is not counted as underflow. Goes to RUN when registered fill >= PREFILL (transition visible next cycle).
- State RUN, m_en=1 and fill >= OUT_LANES: pop.
- State RUN, m_en=1 and fill < OUT_LANES: idle words emitted, underflow<=1, underflow_cnt increments (saturates at 0xFFFF), state->PREFILL. Residual samples are retained and emitted first after refill.
- State RUN, m_en=0: stay in RUN, no action.
- uf_clear: underflow<=0, cnt<=0. If a new underflow occurs the same cycle: underflow=1, cnt=1.
- Buffer: BUF_WORDS x WIDTH shift/realign register or circular array with read pointer. Pointer wrap modulo BUF_WORDS; non-power-of-2 depths must work.
- No overflow is possible by construction (s_ready). Data is never dropped or reordered.

Optional Feature:
DAC_IF_OFFSET_BINARY_EN
- Defined: MSB of every m_data sample (data and IDLE_CODE) is inverted at the output register, converting two's complement to offset binary for DACs requiring it.
- Undefined: samples pass unmodified.

Decomposition:
- Package dac_if_pkg: sample_t (logic [WIDTH-1:0], default 14), UF_CNT_W=16, state enum {PREFILL, RUN}, and the encode function (conditional MSB invert).
- One sub-module, dac_lane_buffer: storage, pointers, fill arithmetic and push/pop. The top level holds the FSM, underflow logic and the output register.

Test Plan:
- Default params: reset, m_en=1 continuous, push ramp beats 0..4, 5..9 -> idle words (m_valid=1) until fill>=8; first RUN output {0,1,2,3}, then {4,5,6,7}; underflow stays 0.
- Continuous ramp with s_valid=1, m_en=1 for 1000 cycles -> s_ready throttles to 4/5 duty; output is a contiguous ramp with no gaps after prefill; underflow_cnt=0.
- Push exactly 3 beats (samples 0..14), m_en=1 -> outputs {0..3}, {4..7}, {8..11}, then idle with underflow=1, cnt=1, running=0, fill=3. Push 1 beat (15..19) -> RUN resumes with {12,13,14,15}.
- m_en=0, s_valid=1 -> fill goes 5, 10, 15; s_ready=0 at fill=15, held without loss. Then m_en=1 drains the data in order.
- Assert reset with fill=12 in RUN -> next cycle fill=0, m_valid=0, running=0, underflow=0, cnt=0. Assert uf_clear together with an underflow event -> underflow=1, cnt=1.
- With DAC_IF_OFFSET_BINARY_EN: sample 0x0000 -> 0x2000, sample 0x3FFF -> 0x1FFF, idle -> 0x2000. Without it: idle -> 0x0000.

Source files
------------

// File: rtl/dac_lane_gearbox_pkg.sv
// Shared types and sample encoding for the DAC lane gearbox.
// Optional build macro: DAC_IF_OFFSET_BINARY_EN (emit offset-binary samples instead of two's complement).
package dac_if_pkg;

  localparam int SAMPLE_W = 14;
  localparam int UF_CNT_W = 16;
  localparam int MAX_W    = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    ST_PREFILL = 1'b0,
    ST_RUN     = 1'b1
  } state_e;

`ifdef DAC_IF_OFFSET_BINARY_EN
  localparam int OFFSET_BIN = 1;
`else
  localparam int OFFSET_BIN = 0;
`endif

  // Flips bit w-1 (the sample MSB) when offset-binary output is built in.
  function automatic logic [MAX_W-1:0] encode(input logic [MAX_W-1:0] s, input int unsigned w);
    logic [MAX_W-1:0] mask;
    mask = MAX_W'(OFFSET_BIN) << (w - 1);
    return s ^ mask;
  endfunction

endpackage

// File: rtl/dac_lane_gearbox_if.sv
// Sample-stream, OSERDES-feed and status bundle of the DAC lane gearbox.
interface dac_lane_gearbox_if #(
  parameter int WIDTH     = 14,
  parameter int IN_LANES  = 5,
  parameter int OUT_LANES = 4,
  parameter int BUF_WORDS = 16
);
  localparam int FILL_W = $clog2(BUF_WORDS + 1);

  logic                               s_valid;
  logic                               s_ready;
  logic [IN_LANES*WIDTH-1:0]          s_data;
  logic                               m_en;
  logic                               m_valid;
  logic [OUT_LANES*WIDTH-1:0]         m_data;
  logic [FILL_W-1:0]                  fill;
  logic                               running;
  logic                               underflow;
  logic [dac_if_pkg::UF_CNT_W-1:0]    underflow_cnt;
  logic                               uf_clear;

  modport slave (
    input  s_valid, s_data, m_en, uf_clear,
    output s_ready, m_valid, m_data, fill, running, underflow, underflow_cnt
  );

  modport master (
    output s_valid, s_data, m_en, uf_clear,
    input  s_ready, m_valid, m_data, fill, running, underflow, underflow_cnt
  );
endinterface

// File: rtl/dac_lane_gearbox_buffer.sv
// Circular sample store: appends IN_LANES samples per push, removes OUT_LANES per pop.
module dac_lane_buffer #(
  parameter int WIDTH     = 14,
  parameter int IN_LANES  = 5,
  parameter int OUT_LANES = 4,
  parameter int BUF_WORDS = 16,
  parameter int FILL_W    = $clog2(BUF_WORDS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [IN_LANES*WIDTH-1:0]  push_data_i,
  input  logic                       pop_i,
  output logic [OUT_LANES*WIDTH-1:0] pop_data_o,
  output logic [FILL_W-1:0]          fill_o
);
  localparam int PTR_W = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;

  logic [WIDTH-1:0]  mem_q [BUF_WORDS];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Indices never reach 2*BUF_WORDS, so one conditional subtract wraps any depth.
  function automatic logic [PTR_W-1:0] wrap(input int unsigned idx);
    return PTR_W'((idx >= int'(BUF_WORDS)) ? idx - int'(BUF_WORDS) : idx);
  endfunction

  always_comb begin
    for (int k = 0; k < OUT_LANES; k++) begin
      pop_data_o[k*WIDTH +: WIDTH] = mem_q[wrap(32'(rd_ptr_q) + 32'(k))];
    end
  end

  // NOTE: every signal written in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (pop_i) begin
      rd_ptr_d = wrap(32'(rd_ptr_q) + 32'(OUT_LANES));
    end
    fill_d = fill_q + (push_i ? FILL_W'(IN_LANES) : '0) - (pop_i ? FILL_W'(OUT_LANES) : '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: the sample array is not reset; fill=0 already marks every entry as empty.
  always_ff @(posedge clk) begin
    if (push_i) begin
      for (int k = 0; k < IN_LANES; k++) begin
        mem_q[wrap(32'(rd_ptr_q) + 32'(fill_q) + 32'(k))] <= push_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign fill_o = fill_q;

endmodule

// File: rtl/dac_lane_gearbox.sv
// Lane-ratio converter feeding a multiplexed DAC: prefill FSM, underflow tracking, output register.
// Optional build macro: DAC_IF_OFFSET_BINARY_EN (output samples in offset binary).
module dac_lane_gearbox
  import dac_if_pkg::*;
#(
  parameter int              WIDTH     = 14,
  parameter int              IN_LANES  = 5,
  parameter int              OUT_LANES = 4,
  parameter int              BUF_WORDS = 16,
  parameter int              PREFILL   = 8,
  parameter logic [WIDTH-1:0] IDLE_CODE = '0
) (
  input  logic               clk,
  input  logic               reset,
  dac_lane_gearbox_if.slave  bus
);
  localparam int               FILL_W   = $clog2(BUF_WORDS + 1);
  localparam logic [WIDTH-1:0] IDLE_ENC = WIDTH'(encode(MAX_W'(IDLE_CODE), WIDTH));

  logic [FILL_W-1:0]          fill;
  logic [OUT_LANES*WIDTH-1:0] pop_data, pop_enc, idle_word;
  logic                       push, pop, uf_event;

  state_e                     state_q, state_d;
  logic                       m_valid_q, m_valid_d;
  logic [OUT_LANES*WIDTH-1:0] m_data_q, m_data_d;
  logic                       underflow_q, underflow_d;
  logic [UF_CNT_W-1:0]        uf_cnt_q, uf_cnt_d;

  dac_lane_buffer #(
    .WIDTH     (WIDTH),
    .IN_LANES  (IN_LANES),
    .OUT_LANES (OUT_LANES),
    .BUF_WORDS (BUF_WORDS),
    .FILL_W    (FILL_W)
  ) u_buffer (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (bus.s_data),
    .pop_i       (pop),
    .pop_data_o  (pop_data),
    .fill_o      (fill)
  );

  // Ready depends only on registered fill, keeping s_valid and m_en off any combinational path.
  assign bus.s_ready = (fill <= FILL_W'(BUF_WORDS - IN_LANES));
  assign push        = bus.s_valid && bus.s_ready;
  assign pop         = (state_q == ST_RUN) && bus.m_en && (fill >= FILL_W'(OUT_LANES));
  assign uf_event    = (state_q == ST_RUN) && bus.m_en && (fill <  FILL_W'(OUT_LANES));
  assign idle_word   = {OUT_LANES{IDLE_ENC}};

  always_comb begin
    for (int k = 0; k < OUT_LANES; k++) begin
      pop_enc[k*WIDTH +: WIDTH] = WIDTH'(encode(MAX_W'(pop_data[k*WIDTH +: WIDTH]), WIDTH));
    end
  end

  always_comb begin
    state_d     = state_q;
    m_valid_d   = bus.m_en;
    m_data_d    = m_data_q;
    underflow_d = underflow_q;
    uf_cnt_d    = uf_cnt_q;

    if (bus.m_en) begin
      m_data_d = pop ? pop_enc : idle_word;
    end

    unique case (state_q)
      ST_PREFILL: if (fill >= FILL_W'(PREFILL)) state_d = ST_RUN;
      ST_RUN:     if (uf_event) state_d = ST_PREFILL;
      default:    state_d = ST_PREFILL;
    endcase

    // A clear and a new underflow in the same cycle leave exactly one counted event.
    if (bus.uf_clear) begin
      underflow_d = 1'b0;
      uf_cnt_d    = '0;
    end
    if (uf_event) begin
      underflow_d = 1'b1;
      if (uf_cnt_d != '1) uf_cnt_d = uf_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PREFILL;
      m_valid_q   <= 1'b0;
      m_data_q    <= idle_word;
      underflow_q <= 1'b0;
      uf_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      underflow_q <= underflow_d;
      uf_cnt_q    <= uf_cnt_d;
    end
  end

  assign bus.m_valid       = m_valid_q;
  assign bus.m_data        = m_data_q;
  assign bus.fill          = fill;
  assign bus.running       = (state_q == ST_RUN);
  assign bus.underflow     = underflow_q;
  assign bus.underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_dac_lane_gearbox.sv
// Directed testbench for dac_lane_gearbox with default parameters (5 -> 4 lanes, 16-deep, prefill 8).
`timescale 1ns/1ps
module tb_dac_lane_gearbox;
  localparam int W  = 14;
  localparam int IL = 5;
  localparam int OL = 4;
  localparam int BW = 16;
`ifdef DAC_IF_OFFSET_BINARY_EN
  localparam logic [W-1:0] MSB_FLIP = 14'h2000;
`else
  localparam logic [W-1:0] MSB_FLIP = 14'h0000;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  dac_lane_gearbox_if #(.WIDTH(W), .IN_LANES(IL), .OUT_LANES(OL), .BUF_WORDS(BW)) bus ();

  dac_lane_gearbox #(
    .WIDTH(W), .IN_LANES(IL), .OUT_LANES(OL), .BUF_WORDS(BW), .PREFILL(8), .IDLE_CODE(14'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [IL*W-1:0] beat(input int base);
    logic [IL*W-1:0] r;
    for (int k = 0; k < IL; k++) r[k*W +: W] = W'(base + k);
    return r;
  endfunction

  function automatic logic [OL*W-1:0] word(input int base);
    logic [OL*W-1:0] r;
    for (int k = 0; k < OL; k++) r[k*W +: W] = W'(base + k) ^ MSB_FLIP;
    return r;
  endfunction

  function automatic logic [OL*W-1:0] idle_word();
    return {OL{MSB_FLIP}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.s_valid = 1'b0; bus.m_en = 1'b0; bus.uf_clear = 1'b0; bus.s_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.fill !== 5'd0) begin n_fail++; $display("FAIL rst_fill got=%0d exp=0", bus.fill); end
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
    n_tests++; if (bus.m_data !== idle_word()) begin n_fail++; $display("FAIL rst_m_data got=%h exp=%h", bus.m_data, idle_word()); end
    n_tests++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL rst_running got=%b exp=0", bus.running); end
    n_tests++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL rst_underflow got=%b exp=0", bus.underflow); end
    n_tests++; if (bus.underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_uf_cnt got=%0d exp=0", bus.underflow_cnt); end
    n_tests++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready got=%b exp=1", bus.s_ready); end
  endtask

  task automatic test_prefill();
    do_reset();
    bus.m_en = 1'b1; bus.s_valid = 1'b1; bus.s_data = beat(0);
    tick();
    n_tests++; if (bus.fill !== 5'd5) begin n_fail++; $display("FAIL pf_fill5 got=%0d exp=5", bus.fill); end
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== idle_word()) begin n_fail++; $display("FAIL pf_idle1 got=%b/%h exp=1/%h", bus.m_valid, bus.m_data, idle_word()); end
    bus.s_data = beat(5);
    tick();
    n_tests++; if (bus.fill !== 5'd10 || bus.running !== 1'b0) begin n_fail++; $display("FAIL pf_fill10 got=%0d/%b exp=10/0", bus.fill, bus.running); end
    bus.s_valid = 1'b0;
    tick();
    n_tests++; if (bus.running !== 1'b1 || bus.m_data !== idle_word()) begin n_fail++; $display("FAIL pf_enter_run got=%b/%h exp=1/%h", bus.running, bus.m_data, idle_word()); end
    tick();
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== word(0)) begin n_fail++; $display("FAIL pf_word0 got=%h exp=%h", bus.m_data, word(0)); end
    tick();
    n_tests++; if (bus.m_data !== word(4) || bus.fill !== 5'd2) begin n_fail++; $display("FAIL pf_word4 got=%h/%0d exp=%h/2", bus.m_data, bus.fill, word(4)); end
    n_tests++; if (bus.underflow !== 1'b0 || bus.underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL pf_no_uf got=%b/%0d exp=0/0", bus.underflow, bus.underflow_cnt); end
    bus.m_en = 1'b0;
    tick();
    n_tests++; if (bus.m_valid !== 1'b0 || bus.m_data !== word(4)) begin n_fail++; $display("FAIL pf_hold got=%b/%h exp=0/%h", bus.m_valid, bus.m_data, word(4)); end
  endtask

  task automatic test_ramp();
    int nxt, exp_base, beats, words;
    bit started, push_will;
    do_reset();
    nxt = 100; exp_base = 100; beats = 0; words = 0; started = 1'b0;
    bus.m_en = 1'b1; bus.s_valid = 1'b1; bus.s_data = beat(nxt);
    for (int c = 0; c < 1000; c++) begin
      push_will = bus.s_ready;
      tick();
      if (push_will) begin beats++; nxt += IL; bus.s_data = beat(nxt); end
      if (bus.m_valid === 1'b1 && (started || bus.m_data !== idle_word())) begin
        started = 1'b1;
        n_tests++;
        if (bus.m_data !== word(exp_base)) begin n_fail++; $display("FAIL ramp_word got=%h exp=%h", bus.m_data, word(exp_base)); end
        exp_base += OL; words++;
      end
    end
    bus.s_valid = 1'b0; bus.m_en = 1'b0;
    n_tests++; if (bus.underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL ramp_uf_cnt got=%0d exp=0", bus.underflow_cnt); end
    n_tests++; if (beats < 790 || beats > 810) begin n_fail++; $display("FAIL ramp_duty got=%0d beats exp=790..810", beats); end
    n_tests++; if (words < 990) begin n_fail++; $display("FAIL ramp_words got=%0d exp>=990", words); end
    n_tests++; if (beats*IL != words*OL + int'(bus.fill)) begin n_fail++; $display("FAIL ramp_conserve got=%0d exp=%0d", beats*IL, words*OL + int'(bus.fill)); end
  endtask

  task automatic test_underflow();
    do_reset();
    bus.m_en = 1'b1; bus.s_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin bus.s_data = beat(b*IL); tick(); end
    bus.s_valid = 1'b0;
    n_tests++; if (bus.fill !== 5'd15 || bus.running !== 1'b1) begin n_fail++; $display("FAIL uf_setup got=%0d/%b exp=15/1", bus.fill, bus.running); end
    for (int g = 0; g < 3; g++) begin
      tick();
      n_tests++; if (bus.m_data !== word(g*OL)) begin n_fail++; $display("FAIL uf_word%0d got=%h exp=%h", g, bus.m_data, word(g*OL)); end
    end
    tick();
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== idle_word()) begin n_fail++; $display("FAIL uf_idle got=%b/%h exp=1/%h", bus.m_valid, bus.m_data, idle_word()); end
    n_tests++; if (bus.underflow !== 1'b1 || bus.underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL uf_flag got=%b/%0d exp=1/1", bus.underflow, bus.underflow_cnt); end
    n_tests++; if (bus.running !== 1'b0 || bus.fill !== 5'd3) begin n_fail++; $display("FAIL uf_state got=%b/%0d exp=0/3", bus.running, bus.fill); end
    bus.s_valid = 1'b1; bus.s_data = beat(15);
    tick();
    bus.s_valid = 1'b0;
    n_tests++; if (bus.fill !== 5'd8 || bus.running !== 1'b0) begin n_fail++; $display("FAIL uf_refill got=%0d/%b exp=8/0", bus.fill, bus.running); end
    tick();
    n_tests++; if (bus.running !== 1'b1 || bus.m_data !== idle_word()) begin n_fail++; $display("FAIL uf_rerun got=%b/%h exp=1/%h", bus.running, bus.m_data, idle_word()); end
    tick();
    bus.m_en = 1'b0;
    n_tests++; if (bus.m_data !== word(12)) begin n_fail++; $display("FAIL uf_resume got=%h exp=%h", bus.m_data, word(12)); end
    n_tests++; if (bus.underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL uf_cnt_stable got=%0d exp=1", bus.underflow_cnt); end
  endtask

  task automatic test_back_to_back();
    int exp_base;
    bit push_will;
    do_reset();
    bus.m_en = 1'b0; bus.s_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.s_data = beat(b*IL);
      tick();
      n_tests++; if (bus.fill !== 5'(5*(b+1))) begin n_fail++; $display("FAIL bp_fill got=%0d exp=%0d", bus.fill, 5*(b+1)); end
    end
    bus.s_data = beat(15);
    tick(); tick();
    n_tests++; if (bus.fill !== 5'd15 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold got=%0d/%b exp=15/0", bus.fill, bus.s_ready); end
    bus.m_en = 1'b1; exp_base = 0;
    for (int c = 0; c < 10 && exp_base < 20; c++) begin
      push_will = bus.s_valid && bus.s_ready;
      tick();
      if (push_will) bus.s_valid = 1'b0;
      if (bus.m_valid === 1'b1) begin
        n_tests++;
        if (bus.m_data !== word(exp_base)) begin n_fail++; $display("FAIL bp_drain got=%h exp=%h", bus.m_data, word(exp_base)); end
        exp_base += OL;
      end
    end
    bus.m_en = 1'b0; bus.s_valid = 1'b0;
    n_tests++; if (exp_base != 20 || bus.fill !== 5'd0) begin n_fail++; $display("FAIL bp_complete got=%0d/%0d exp=20/0", exp_base, bus.fill); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    bus.m_en = 1'b0; bus.s_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin bus.s_data = beat(b*IL); tick(); end
    bus.s_data = beat(15); bus.m_en = 1'b1;
    tick(); tick();
    bus.s_valid = 1'b0; bus.m_en = 1'b0;
    n_tests++; if (bus.fill !== 5'd12 || bus.running !== 1'b1) begin n_fail++; $display("FAIL rr_setup got=%0d/%b exp=12/1", bus.fill, bus.running); end
    reset = 1'b1; bus.s_valid = 1'b1; bus.m_en = 1'b1;
    tick();
    reset = 1'b0; bus.s_valid = 1'b0; bus.m_en = 1'b0;
    n_tests++; if (bus.fill !== 5'd0 || bus.m_valid !== 1'b0 || bus.running !== 1'b0) begin n_fail++; $display("FAIL rr_clear got=%0d/%b/%b exp=0/0/0", bus.fill, bus.m_valid, bus.running); end
    n_tests++; if (bus.m_data !== idle_word()) begin n_fail++; $display("FAIL rr_m_data got=%h exp=%h", bus.m_data, idle_word()); end
  endtask

  task automatic push_two();
    bus.s_valid = 1'b1;
    bus.s_data = beat(0); tick();
    bus.s_data = beat(5); tick();
    bus.s_valid = 1'b0;
    tick();
  endtask

  task automatic test_uf_clear();
    do_reset();
    push_two();                          // fill 10, RUN
    bus.m_en = 1'b1; tick(); tick(); tick();
    bus.m_en = 1'b0;
    n_tests++; if (bus.underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL ufc_cnt1 got=%0d exp=1", bus.underflow_cnt); end
    push_two();                          // fill 2 -> 12, RUN
    bus.m_en = 1'b1; tick(); tick(); tick(); tick();
    bus.m_en = 1'b0;
    n_tests++; if (bus.underflow !== 1'b1 || bus.underflow_cnt !== 16'd2) begin n_fail++; $display("FAIL ufc_cnt2 got=%b/%0d exp=1/2", bus.underflow, bus.underflow_cnt); end
    bus.uf_clear = 1'b1; tick(); bus.uf_clear = 1'b0;
    n_tests++; if (bus.underflow !== 1'b0 || bus.underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL ufc_clear got=%b/%0d exp=0/0", bus.underflow, bus.underflow_cnt); end
    push_two();                          // fill 0 -> 10, RUN
    bus.m_en = 1'b1; tick(); tick();
    bus.uf_clear = 1'b1; tick();
    bus.uf_clear = 1'b0; bus.m_en = 1'b0;
    n_tests++; if (bus.underflow !== 1'b1 || bus.underflow_cnt !== 16'd1) begin n_fail++; $display("FAIL ufc_same_cycle got=%b/%0d exp=1/1", bus.underflow, bus.underflow_cnt); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++; if (bus.underflow !== 1'b0 || bus.underflow_cnt !== 16'd0) begin n_fail++; $display("FAIL ufc_reset got=%b/%0d exp=0/0", bus.underflow, bus.underflow_cnt); end
  endtask

  task automatic test_encoding();
    logic [IL*W-1:0] raw;
    logic [OL*W-1:0] exp_w;
    logic [W-1:0]    exp_idle;
    do_reset();
    raw = {14'h0001, 14'h1FFF, 14'h2000, 14'h3FFF, 14'h0000};
    for (int k = 0; k < OL; k++) exp_w[k*W +: W] = raw[k*W +: W] ^ MSB_FLIP;
`ifdef DAC_IF_OFFSET_BINARY_EN
    exp_idle = 14'h2000;
`else
    exp_idle = 14'h0000;
`endif
    bus.m_en = 1'b1; bus.s_valid = 1'b1; bus.s_data = raw;
    tick();
    n_tests++; if (bus.m_data[W-1:0] !== exp_idle) begin n_fail++; $display("FAIL enc_idle got=%h exp=%h", bus.m_data[W-1:0], exp_idle); end
    bus.m_en = 1'b0; bus.s_data = beat(0);
    tick();
    bus.s_valid = 1'b0;
    tick();
    bus.m_en = 1'b1;
    tick();
    bus.m_en = 1'b0;
    n_tests++; if (bus.m_data !== exp_w) begin n_fail++; $display("FAIL enc_data got=%h exp=%h", bus.m_data, exp_w); end
  endtask

  initial begin
    reset = 1'b1;
    bus.s_valid = 1'b0; bus.m_en = 1'b0; bus.uf_clear = 1'b0; bus.s_data = '0;
    test_reset();
    test_prefill();
    test_ramp();
    test_underflow();
    test_back_to_back();
    test_reset_midrun();
    test_uf_clear();
    test_encoding();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
